// File: rtl/l1a_check_pkg.sv
// Shared types and default sizing for the L1A check responder.
package l1a_check_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_HDR = 2'd1,
    REPORT   = 2'd2,
    GAP      = 2'd3
  } state_e;

  localparam logic [1:0] GRP0 = 2'b01;
  localparam logic [1:0] GRP1 = 2'b10;

  localparam int unsigned ADC_PER_GRP_DEF = 8;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned ID_W_DEF        = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/l1a_hdr_compare.sv
// Combinational check of one ADC header against the expected id and L1A count.
module l1a_hdr_compare
  import l1a_check_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic [ID_W-1:0]  hdr_id,
  input  logic [ID_W-1:0]  exp_id,
  input  logic [CNT_W-1:0] hdr_l1a,
  input  logic [CNT_W-1:0] exp_l1a,
  output logic             mismatch,
  output logic             id_err
);

  always_comb begin
    id_err   = (hdr_id != exp_id);
    mismatch = id_err || (hdr_l1a != exp_l1a);
  end

endmodule

// File: rtl/l1a_check_responder.sv
// Responder for the L1A check handshake: checks one ADC group per start_check request.
// Optional header-wait timeout enabled by defining L1A_CHECK_TIMEOUT_EN.
module l1a_check_responder
  import l1a_check_pkg::*;
#(
  parameter int unsigned ADC_PER_GRP = ADC_PER_GRP_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned ID_W        = ID_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               start_check,
  input  logic [CNT_W-1:0]         expected_l1a,
  input  logic                     adc_hdr_valid,
  output logic                     adc_hdr_ready,
  input  logic [ID_W-1:0]          adc_hdr_id,
  input  logic [CNT_W-1:0]         adc_hdr_l1a,
  input  logic                     clear_err,
  output logic                     one_adc_finish_check,
  output logic                     busy,
  output logic [2*ADC_PER_GRP-1:0] mismatch_mask,
  output logic                     id_err,
  output logic                     timeout_err
);

  localparam int unsigned IDX_W    = (ADC_PER_GRP > 1) ? $clog2(ADC_PER_GRP) : 1;
  localparam int unsigned MASK_W   = 2 * ADC_PER_GRP;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ADC_PER_GRP - 1);

  state_e              state_q, state_d;
  logic                grp_q, grp_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    l1a_q, l1a_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic                id_err_q, id_err_d;
  logic                ready_q, ready_d;
  logic                finish_q, finish_d;
  logic                busy_q, busy_d;

  logic                hs;
  logic                to_hit;
  logic [ID_W-1:0]     exp_id;
  logic                cmp_mismatch;
  logic                cmp_id_err;
  int unsigned         grp_base;
  int unsigned         to_lo;

  // ready_q is high exactly while in WAIT_HDR
  assign hs       = adc_hdr_valid && ready_q;
  assign grp_base = grp_q ? ADC_PER_GRP : 32'd0;
  assign to_lo    = grp_base + 32'(idx_q);
  assign exp_id   = (grp_q ? ID_W'(ADC_PER_GRP) : '0) + ID_W'(idx_q);

  l1a_hdr_compare #(
    .CNT_W (CNT_W),
    .ID_W  (ID_W)
  ) u_cmp (
    .hdr_id   (adc_hdr_id),
    .exp_id   (exp_id),
    .hdr_l1a  (adc_hdr_l1a),
    .exp_l1a  (l1a_q),
    .mismatch (cmp_mismatch),
    .id_err   (cmp_id_err)
  );

`ifdef L1A_CHECK_TIMEOUT_EN
  localparam int unsigned WC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WC_W-1:0] wait_q, wait_d;
  logic            to_err_q, to_err_d;

  assign to_hit = ready_q && !adc_hdr_valid && (wait_q == WC_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wait_d   = (ready_q && !hs && !to_hit) ? wait_q + WC_W'(1) : '0;
    to_err_d = clear_err ? 1'b0 : to_err_q;
    if (to_hit) to_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q   <= '0;
      to_err_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    idx_d    = idx_q;
    l1a_d    = l1a_q;
    mask_d   = mask_q;
    id_err_d = clear_err ? 1'b0 : id_err_q;

    case (state_q)
      IDLE: begin
        if (start_check == GRP0) begin
          l1a_d   = expected_l1a;
          mask_d  = '0;
          grp_d   = 1'b0;
          idx_d   = '0;
          state_d = WAIT_HDR;
        end else if (start_check == GRP1) begin
          grp_d   = 1'b1;
          idx_d   = '0;
          state_d = WAIT_HDR;
        end
      end
      WAIT_HDR: begin
        if (hs) begin
          for (int unsigned j = 0; j < MASK_W; j++) begin
            if (cmp_mismatch && (j == 32'(exp_id))) mask_d[j] = 1'b1;
          end
          if (cmp_id_err) id_err_d = 1'b1;
          if (idx_q == IDX_LAST) state_d = REPORT;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else if (to_hit) begin
          // ADCs from the current index to the end of the group never reported
          for (int unsigned j = 0; j < MASK_W; j++) begin
            if ((j >= to_lo) && (j < grp_base + ADC_PER_GRP)) mask_d[j] = 1'b1;
          end
          state_d = REPORT;
        end
      end
      REPORT:  state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d  = (state_d == WAIT_HDR);
    finish_d = (state_d == REPORT);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grp_q    <= 1'b0;
      idx_q    <= '0;
      l1a_q    <= '0;
      mask_q   <= '0;
      id_err_q <= 1'b0;
      ready_q  <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      idx_q    <= idx_d;
      l1a_q    <= l1a_d;
      mask_q   <= mask_d;
      id_err_q <= id_err_d;
      ready_q  <= ready_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  assign adc_hdr_ready        = ready_q;
  assign one_adc_finish_check = finish_q;
  assign busy                 = busy_q;
  assign mismatch_mask        = mask_q;
  assign id_err               = id_err_q;

endmodule

// File: tb/tb_l1a_check_responder.sv
// Scoreboard bench for l1a_check_responder; timeout scenario follows L1A_CHECK_TIMEOUT_EN.
module tb_l1a_check_responder;

  localparam int N  = 8;
  localparam int CW = 16;
  localparam int IW = 4;
  localparam int MW = 2 * N;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    start_check;
  logic [CW-1:0] expected_l1a;
  logic          adc_hdr_valid;
  logic          adc_hdr_ready;
  logic [IW-1:0] adc_hdr_id;
  logic [CW-1:0] adc_hdr_l1a;
  logic          clear_err;
  logic          one_adc_finish_check;
  logic          busy;
  logic [MW-1:0] mismatch_mask;
  logic          id_err;
  logic          timeout_err;

  always #5 clk = ~clk;

  l1a_check_responder #(
    .ADC_PER_GRP (N),
    .CNT_W       (CW),
    .ID_W        (IW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start_check          (start_check),
    .expected_l1a         (expected_l1a),
    .adc_hdr_valid        (adc_hdr_valid),
    .adc_hdr_ready        (adc_hdr_ready),
    .adc_hdr_id           (adc_hdr_id),
    .adc_hdr_l1a          (adc_hdr_l1a),
    .clear_err            (clear_err),
    .one_adc_finish_check (one_adc_finish_check),
    .busy                 (busy),
    .mismatch_mask        (mismatch_mask),
    .id_err               (id_err),
    .timeout_err          (timeout_err)
  );

  typedef struct packed {
    logic [MW-1:0] mask;
    logic          id_err;
    logic          to_err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model of the responder's observable results
  logic [CW-1:0] m_l1a;
  logic [MW-1:0] m_mask;
  logic          m_id_err;
  logic          m_to_err;
  int            cur_grp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  always @(negedge clk) begin
    if (one_adc_finish_check === 1'b1) begin
      if (sb_q.size() == 0) begin
        bound_fail("unexpected_finish");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("finish_mask", 32'(mismatch_mask), 32'(e.mask));
        check("finish_id_err", 32'(id_err), 32'(e.id_err));
        check("finish_timeout_err", 32'(timeout_err), 32'(e.to_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    adc_hdr_valid = 1'b0;
    adc_hdr_id    = IW'($urandom);
    adc_hdr_l1a   = CW'($urandom);
  endtask

  task automatic start_grp(input int g);
    if (g == 0) begin
      m_l1a  = expected_l1a;
      m_mask = '0;
    end
    cur_grp     = g;
    start_check = (g == 0) ? 2'b01 : 2'b10;
    tick();
    start_check  = 2'b00;
    expected_l1a = CW'($urandom);
  endtask

  task automatic send_hdr(input int k, input logic [IW-1:0] id, input logic [CW-1:0] l1a,
                          input int gap);
    int  expid;
    bit  ok;
    repeat (gap) tick();
    expid = cur_grp * N + k;
    if (l1a != m_l1a || int'(id) != expid) m_mask[expid] = 1'b1;
    if (int'(id) != expid) m_id_err = 1'b1;
    adc_hdr_valid = 1'b1;
    adc_hdr_id    = id;
    adc_hdr_l1a   = l1a;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (adc_hdr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("hdr_ready_wait");
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic wait_finish(input int bound);
    bit found;
    found = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (one_adc_finish_check === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("finish_seen", 32'(found), 32'd1);
    @(negedge clk);
    check("finish_one_cycle", 32'(one_adc_finish_check), 32'd0);
    check("busy_in_gap", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_idle_after_gap", 32'(busy), 32'd0);
  endtask

  task automatic run_group(input int g, input int bad_l1a_k, input int bad_id_k,
                           input logic [IW-1:0] bad_id, input bit rnd_gap);
    logic [IW-1:0] id;
    logic [CW-1:0] l1a;
    start_grp(g);
    for (int k = 0; k < N; k++) begin
      id  = IW'(g * N + k);
      l1a = m_l1a;
      if (k == bad_l1a_k) l1a = m_l1a + CW'(1);
      if (k == bad_id_k)  id  = bad_id;
      send_hdr(k, id, l1a, rnd_gap ? int'($urandom_range(0, 5)) : 0);
    end
    sb_q.push_back('{mask: m_mask, id_err: m_id_err, to_err: m_to_err});
    wait_finish(20);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    m_id_err  = 1'b0;
    m_to_err  = 1'b0;
    @(negedge clk);
    check("id_err_cleared", 32'(id_err), 32'(m_id_err));
    check("timeout_err_cleared", 32'(timeout_err), 32'(m_to_err));
    check("mask_kept_after_clear", 32'(mismatch_mask), 32'(m_mask));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(adc_hdr_ready), 32'd0);
    check("rst_finish", 32'(one_adc_finish_check), 32'd0);
    check("rst_mask", 32'(mismatch_mask), 32'd0);
    check("rst_id_err", 32'(id_err), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    m_mask = '0; m_id_err = 1'b0; m_to_err = 1'b0; m_l1a = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    start_check  = 2'b00;
    expected_l1a = '0;
    clear_err    = 1'b0;
    idle_bus();
    m_mask = '0; m_id_err = 1'b0; m_to_err = 1'b0; m_l1a = '0; cur_grp = 0;
    #12;
    do_reset();

    // T1 nominal, both groups
    expected_l1a = 16'h0123;
    run_group(0, -1, -1, '0, 1'b0);
    run_group(1, -1, -1, '0, 1'b0);
    check("t1_mask_zero", 32'(mismatch_mask), 32'd0);

    // T2 L1A mismatch at ADC 3, T3 id error in 5th header of group 1
    expected_l1a = 16'h0BEE;
    run_group(0, 3, -1, '0, 1'b0);
    check("t2_mask", 32'(mismatch_mask), 32'h0008);
    check("t2_id_err", 32'(id_err), 32'd0);
    run_group(1, -1, 4, 4'd2, 1'b0);
    check("t3_mask", 32'(mismatch_mask), 32'h1008);
    check("t3_id_err", 32'(id_err), 32'd1);
    pulse_clear();

    // T4 randomized content with back-pressure gaps
    for (int r = 0; r < 6; r++) begin
      expected_l1a = CW'($urandom);
      for (int g = 0; g < 2; g++) begin
        run_group(g, int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                  IW'($urandom), 1'b1);
        if ($urandom_range(0, 2) == 0) pulse_clear();
      end
    end

    // T5 start 11 ignored, then reset in the middle of a group
    start_check = 2'b11;
    repeat (3) tick();
    @(negedge clk);
    check("t5_busy_on_11", 32'(busy), 32'd0);
    check("t5_ready_on_11", 32'(adc_hdr_ready), 32'd0);
    start_check = 2'b00;
    tick();
    expected_l1a = 16'h5555;
    start_grp(0);
    send_hdr(0, 4'd5, 16'h1111, 0);
    send_hdr(1, 4'd1, m_l1a, 0);
    send_hdr(2, 4'd2, m_l1a, 0);
    @(negedge clk);
    check("t5_mask_before_reset", 32'(mismatch_mask), 32'(m_mask));
    check("t5_busy_before_reset", 32'(busy), 32'd1);
    do_reset();
    repeat (10) tick();
    @(negedge clk);
    check("t5_idle_after_reset", 32'(busy), 32'd0);

    // T6 header silence after two headers
    expected_l1a = 16'h0777;
    start_grp(0);
    send_hdr(0, 4'd0, m_l1a, 0);
    send_hdr(1, 4'd1, m_l1a, 0);
`ifdef L1A_CHECK_TIMEOUT_EN
    for (int i = 2; i < N; i++) m_mask[i] = 1'b1;
    m_to_err = 1'b1;
    sb_q.push_back('{mask: m_mask, id_err: m_id_err, to_err: m_to_err});
    wait_finish(40);
    check("t6_mask", 32'(mismatch_mask), 32'h00FC);
    check("t6_timeout_err", 32'(timeout_err), 32'd1);
    pulse_clear();
`else
    repeat (1000) tick();
    @(negedge clk);
    check("t6_still_busy", 32'(busy), 32'd1);
    check("t6_still_ready", 32'(adc_hdr_ready), 32'd1);
    check("t6_no_timeout_err", 32'(timeout_err), 32'd0);
    do_reset();
`endif

    repeat (5) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
